// File: rtl/chan_overflow_accum.sv
// chan_overflow_accum: multi-channel unsigned accumulator with sticky overflow, wrap/saturate and a handshaked flush
//   clk, rst_n (async, active low)
//   sat_en, in_valid, in_ch, in_data / in_ready : channel-tagged addend stream
//   flush_req                                   : start draining every channel
//   out_valid, out_ch, out_data, out_ovf / out_ready : one flush word per channel, ascending
//   ovf_pulse, drop_pulse                       : one-cycle flags for the previous accepted beat
module chan_overflow_accum #(
   parameter int WIDTH = 4,
   parameter int CHANNELS = 2,
   localparam int CH_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sat_en,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH_W-1:0] in_ch,
   input  logic [WIDTH-1:0] in_data,
   input  logic            flush_req,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CH_W-1:0] out_ch,
   output logic [WIDTH-1:0] out_data,
   output logic            out_ovf,
   output logic            ovf_pulse,
   output logic            drop_pulse
);
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;
   logic [0:0]          state;
   logic [CH_W-1:0]     cnt;
   logic [WIDTH-1:0]    acc [CHANNELS];
   logic [CHANNELS-1:0] ovf;
   logic                in_range, carry, last, flushing;
   logic [CH_W-1:0]     idx;
   logic [WIDTH:0]      sum;
   logic [WIDTH-1:0]    nxt;
   assign flushing = state == FLUSH;
   assign in_ready = !flushing;
   assign out_valid = flushing;
   assign out_ch = cnt;
   assign out_data = flushing ? acc[cnt] : '0;
   assign out_ovf = flushing & ovf[cnt];
   // Tags beyond CHANNELS exist only for non-power-of-2 counts; idx keeps the array read in bounds.
   assign in_range = int'(in_ch) < CHANNELS;
   assign idx = in_range ? in_ch : '0;
   assign sum = {1'b0, acc[idx]} + {1'b0, in_data};
   assign carry = sum[WIDTH];
   assign nxt = (sat_en && carry) ? '1 : sum[WIDTH-1:0];
   assign last = cnt == CH_W'(CHANNELS - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt <= '0;
         acc <= '{default: '0};
         ovf <= '0;
         ovf_pulse <= 1'b0;
         drop_pulse <= 1'b0;
      end else begin
         ovf_pulse <= 1'b0;
         drop_pulse <= 1'b0;
         case (state)
            RUN: begin
               if (in_valid) begin
                  if (in_range) begin
                     acc[idx] <= nxt;
                     if (carry) begin
                        ovf[idx] <= 1'b1;
                        ovf_pulse <= 1'b1;
                     end
                  end else begin
                     drop_pulse <= 1'b1;
                  end
               end
               if (flush_req) begin
                  state <= FLUSH;
                  cnt <= '0;
               end
            end
            FLUSH: begin
               if (out_ready) begin
                  acc[cnt] <= '0;
                  ovf[cnt] <= 1'b0;
                  cnt <= last ? '0 : cnt + CH_W'(1);
                  if (last) state <= RUN;
               end
            end
            default: begin
               state <= RUN;
               cnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: doc/chan_overflow_accum.md
# chan_overflow_accum

Parametrised multi-channel unsigned accumulator with per-channel overflow detection, runtime-selectable wrap or saturate arithmetic, and a handshaked flush sequencer. It generalises the single 4-bit `a + b` overflow case into a lint-clean, fully cased, single-driver sequential block. It sits between a channel-tagged sample stream and a result consumer that drains all channel sums on request.

## Interface
- WIDTH, 4: data and accumulator width, unsigned, ≥2.
- CHANNELS, 2: number of independent accumulators, ≥2.
- CH_W (localparam): clog2(CHANNELS), minimum 1.

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sat_en  in  1  0 = wrap mode, 1 = saturate mode; sampled per accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_ch  in  CH_W  channel tag of the beat.
- in_data  in  WIDTH  addend.
- flush_req  in  1  single-cycle request to drain all channels.
- out_valid  out  1  flush word valid.
- out_ready  in  1  consumer accepts the flush word.
- out_ch  out  CH_W  channel of the flush word.
- out_data  out  WIDTH  accumulated value of out_ch.
- out_ovf  out  1  sticky overflow of out_ch.
- ovf_pulse  out  1  one-cycle pulse: an accepted beat overflowed.
- drop_pulse  out  1  one-cycle pulse: an accepted beat had in_ch ≥ CHANNELS.

## Operation
- FSM states: RUN, FLUSH. Every case statement is fully specified with a default; no latches; each register has exactly one driving always block.
- RUN: in_ready = 1. A beat is accepted when in_valid && in_ready.
- Arithmetic: sum = {1'b0, acc[in_ch]} + {1'b0, in_data} (WIDTH+1 bits); carry = sum[WIDTH].
  - Wrap: acc <= sum[WIDTH-1:0]. Saturate: acc <= carry ? all-ones : sum[WIDTH-1:0].
  - On carry, in either mode: ovf_sticky[in_ch] <= 1 and ovf_pulse = 1 on the next cycle.
- Out-of-range in_ch (≥ CHANNELS, only possible for non-power-of-2 CHANNELS): the beat is accepted and discarded. drop_pulse = 1 on the next cycle. No accumulator changes.
- RUN → FLUSH when flush_req = 1 is sampled. Any beat accepted in the same cycle is included in the flush.
- FLUSH:
  - in_ready = 0. flush_req is ignored.
  - Channel counter starts at 0. out_valid = 1, with out_ch = counter, out_data = acc[counter], out_ovf = ovf_sticky[counter].
  - On out_valid && out_ready: acc[counter] <= 0, ovf_sticky[counter] <= 0, counter increments.
  - After the handshake of channel CHANNELS-1: FSM → RUN, out_valid = 0.
- Flush words are emitted strictly in ascending channel order. out_ch, out_data and out_ovf stay stable while out_valid && !out_ready.

## Timing
- Reset (async assert, values held while rst_n = 0):
  - State = RUN; all acc = 0; all ovf_sticky = 0; counter = 0.
  - in_ready = 1 after rst_n deasserts; out_valid = 0, out_ch = 0, out_data = 0, out_ovf = 0, ovf_pulse = 0, drop_pulse = 0.
- Accumulate latency: a beat accepted at edge k is visible in acc at edge k, and readable in flush from cycle k+1.
- Flush latency: flush_req sampled at edge k gives state FLUSH, in_ready = 0 and out_valid = 1 from edge k. With out_ready held high, each channel takes 1 cycle, so RUN resumes CHANNELS cycles later.
- in_ready and out_valid are decoded from registered state only; no combinational input-to-output paths.
- Reset asserted mid-flush aborts the flush. All state clears immediately; words not yet emitted are lost.
- Saturated accumulators stay at all-ones until flushed. Further beats with carry keep pulsing ovf_pulse.

## Test plan
- Reset: assert rst_n = 0 mid-activity → all outputs and accumulators 0 asynchronously; in_ready = 1 the first cycle after release.
- Wrap (WIDTH = 4, CHANNELS = 3, sat_en = 0): ch0 beats 9, 9 → acc0 = 2; ovf_pulse high exactly one cycle after the second beat; ovf_sticky[0] = 1.
- Saturate (sat_en = 1): ch1 beats 12, 7, 0 → acc1 = 15, 15, 15; ovf_pulse on the second beat only.
- Flush with backpressure: acc = {5, 0, 3}, ovf = {0, 0, 0}; flush_req; out_ready low 3 cycles then high.
  - Required words: (0,5,0), (1,0,0), (2,3,0); word 0 stable during the stall.
  - in_ready = 0 throughout; RUN afterwards with all acc = 0.
- Simultaneous: flush_req and ch1 beat 4 in the same cycle with acc1 = 2 → first RUN-exit word for ch1 reads 6. A flush_req issued during FLUSH has no effect.
- Drop and abort: beat with in_ch = 3 → drop_pulse 1 cycle, acc unchanged. Assert reset after word 0 of a flush is accepted → RUN, out_valid = 0, all acc = 0.
